cmd_deser_fifo: RTL and testbench

CMD_DESER_FIFO -- requirements
Module: cmd_deser_fifo

---
 rtl/cmd_deser_fifo.sv | 194 +++++++++++++++++++
 tb/tb_cmd_deser_fifo.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_deser_fifo.sv
// Byte-serial command deserializer: matches a 1-2 byte address, gathers 0-4
// data bytes, and queues completed {addr,data} commands in a small FIFO.
module cmd_deser_fifo #(
  parameter logic [15:0] ADDR       = 16'h0000,
  parameter logic [15:0] ADDR_MASK  = 16'hffff,
  parameter int unsigned ADDR_BYTES = 2,
  parameter int unsigned DATA_BYTES = 4,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_LOG2  = 2
) (
  input  logic                  rst,
  input  logic                  clk,
  input  logic [7:0]            ad,
  input  logic                  stb,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic [FIFO_LOG2:0]    fill,
  output logic                  overflow,
  input  logic                  ovf_clr,
  output logic                  abort
);

  localparam int unsigned DEPTH = 1 << FIFO_LOG2;
  localparam int unsigned FW    = FIFO_LOG2 + 1;
  localparam int unsigned PW    = FIFO_LOG2;
  localparam logic [2:0]  DATA_LAST = (DATA_BYTES == 0) ? 3'd0 : 3'(DATA_BYTES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AHI  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]  r_state, w_state_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic [15:0] r_acap, w_acap_nxt;
  logic [31:0] r_dcap, w_dcap_nxt;
  logic        w_complete;
  logic        w_abort;
  logic        w_lo_match;
  logic        w_hi_match;

  logic [ADDR_WIDTH-1:0] r_mem_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         w_rd_inc;
  logic [FW-1:0]         r_fill, w_fill_nxt;
  logic                  r_valid;
  logic                  r_overflow;
  logic                  r_abort;
  logic [ADDR_WIDTH-1:0] r_head_addr, w_head_addr_nxt;
  logic [DATA_WIDTH-1:0] r_head_data, w_head_data_nxt;
  logic [ADDR_WIDTH-1:0] w_push_addr;
  logic [DATA_WIDTH-1:0] w_push_data;
  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;

  assign w_lo_match = ((ad ^ ADDR[7:0])  & ADDR_MASK[7:0])  == 8'h00;
  assign w_hi_match = ((ad ^ ADDR[15:8]) & ADDR_MASK[15:8]) == 8'h00;

  // Deserializer next state; a strobe always restarts as an IDLE start byte.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acap_nxt  = r_acap;
    w_dcap_nxt  = r_dcap;
    w_complete  = 1'b0;
    w_abort     = 1'b0;
    if (stb) begin
      w_abort     = (r_state != S_IDLE);
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = 3'd0;
      if (w_lo_match) begin
        w_acap_nxt = {8'h00, ad};
        w_dcap_nxt = 32'h0;
        if (ADDR_BYTES == 2)      w_state_nxt = S_AHI;
        else if (DATA_BYTES == 0) w_complete  = 1'b1;
        else                      w_state_nxt = S_DATA;
      end
    end else begin
      case (r_state)
        S_AHI: begin
          w_state_nxt = S_IDLE;
          if (w_hi_match) begin
            w_acap_nxt = {ad, r_acap[7:0]};
            if (DATA_BYTES == 0) w_complete  = 1'b1;
            else                 w_state_nxt = S_DATA;
          end
        end
        S_DATA: begin
          w_dcap_nxt = r_dcap | (32'(ad) << {r_cnt, 3'b000});
          w_cnt_nxt  = r_cnt + 3'd1;
          if (r_cnt == DATA_LAST) begin
            w_complete  = 1'b1;
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 3'd0;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_acap  <= 16'h0;
      r_dcap  <= 32'h0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_acap  <= w_acap_nxt;
      r_dcap  <= w_dcap_nxt;
      r_abort <= w_abort;
    end
  end

  assign w_push_addr = w_acap_nxt[ADDR_WIDTH-1:0];
  assign w_push_data = w_dcap_nxt[DATA_WIDTH-1:0];
  assign w_full      = (r_fill == FW'(DEPTH));
  assign w_pop       = r_valid & ready;
  assign w_push      = w_complete & (~w_full | w_pop);
  assign w_drop      = w_complete & w_full & ~w_pop;
  assign w_rd_inc    = r_rd_ptr + PW'(1);

  always_comb begin
    w_fill_nxt = r_fill;
    if (w_push && !w_pop)      w_fill_nxt = r_fill + FW'(1);
    else if (w_pop && !w_push) w_fill_nxt = r_fill - FW'(1);
  end

  // Registered head: next entry, or the incoming command when it lands at the head.
  always_comb begin
    w_head_addr_nxt = r_head_addr;
    w_head_data_nxt = r_head_data;
    if (w_fill_nxt == FW'(0)) begin
      w_head_addr_nxt = '0;
      w_head_data_nxt = '0;
    end else if (w_pop) begin
      if (r_fill == FW'(1)) begin
        w_head_addr_nxt = w_push_addr;
        w_head_data_nxt = w_push_data;
      end else begin
        w_head_addr_nxt = r_mem_addr[w_rd_inc];
        w_head_data_nxt = r_mem_data[w_rd_inc];
      end
    end else if (r_fill == FW'(0)) begin
      w_head_addr_nxt = w_push_addr;
      w_head_data_nxt = w_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= w_push_addr;
      r_mem_data[r_wr_ptr] <= w_push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fill      <= '0;
      r_valid     <= 1'b0;
      r_overflow  <= 1'b0;
      r_head_addr <= '0;
      r_head_data <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= w_rd_inc;
      r_fill      <= w_fill_nxt;
      r_valid     <= (w_fill_nxt != FW'(0));
      r_head_addr <= w_head_addr_nxt;
      r_head_data <= w_head_data_nxt;
      if (w_drop)       r_overflow <= 1'b1;
      else if (ovf_clr) r_overflow <= 1'b0;
    end
  end

  assign addr     = r_head_addr;
  assign data     = r_head_data;
  assign valid    = r_valid;
  assign fill     = r_fill;
  assign overflow = r_overflow;
  assign abort    = r_abort;

endmodule

// File: tb/tb_cmd_deser_fifo.sv
// Self-checking bench for cmd_deser_fifo: table of commands plus scoreboard
// of expected FIFO pops, with hand-written abort, overflow and reset sequences.
module tb_cmd_deser_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ad;
  logic        stb;
  logic        ready;
  logic        ovf_clr;

  logic [15:0] addr;
  logic [31:0] data;
  logic        valid;
  logic [2:0]  fill;
  logic        overflow;
  logic        abort;

  logic [15:0] m_addr;
  logic [31:0] m_data;
  logic        m_valid;
  logic [2:0]  m_fill;
  logic        m_overflow;
  logic        m_abort;

  always #5 clk = ~clk;

  cmd_deser_fifo #(.ADDR(16'h1234)) u_dut (
    .rst(rst), .clk(clk), .ad(ad), .stb(stb), .addr(addr), .data(data),
    .valid(valid), .ready(ready), .fill(fill), .overflow(overflow),
    .ovf_clr(ovf_clr), .abort(abort)
  );

  cmd_deser_fifo #(.ADDR(16'h1234), .ADDR_MASK(16'hff00)) u_dut_m (
    .rst(rst), .clk(clk), .ad(ad), .stb(stb), .addr(m_addr), .data(m_data),
    .valid(m_valid), .ready(ready), .fill(m_fill), .overflow(m_overflow),
    .ovf_clr(ovf_clr), .abort(m_abort)
  );

  typedef struct {
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [31:0] d;
    bit          ok;
  } vec_t;

  int          n_chk = 0;
  int          n_err = 0;
  int          abort_cnt = 0;
  int          m_abort_cnt = 0;
  logic [47:0] exp_q [$];
  vec_t        vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every accepted head is compared with the oldest expected command.
  always @(negedge clk) begin
    if (!rst) begin
      if (abort)   abort_cnt++;
      if (m_abort) m_abort_cnt++;
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_pop: got addr 0x%0h data 0x%0h, expected no entry", addr, data);
        end else begin
          logic [47:0] e;
          e = exp_q.pop_front();
          check("pop_addr", 32'(addr), 32'(e[47:32]));
          check("pop_data", data, e[31:0]);
        end
      end
    end
  end

  task automatic drive_byte(input logic [7:0] b, input logic s);
    ad  = b;
    stb = s;
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] lo, input logic [7:0] hi, input logic [31:0] d,
                          input bit rdy_last, input bit clr_last);
    logic [7:0] b [6];
    logic       save;
    b[0] = lo;
    b[1] = hi;
    for (int k = 0; k < 4; k++) b[2+k] = d[8*k +: 8];
    save = ready;
    for (int i = 0; i < 6; i++) begin
      ad  = b[i];
      stb = (i == 0);
      if (i == 5) begin
        if (rdy_last) ready = 1'b1;
        ovf_clr = clr_last;
      end
      @(posedge clk);
      #1;
    end
    stb     = 1'b0;
    ad      = 8'h00;
    ready   = save;
    ovf_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    stb     = 1'b0;
    ad      = 8'h00;
    ovf_clr = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{lo: 8'h34, hi: 8'h12, d: 32'h12345678, ok: 1'b1};
    vecs[1] = '{lo: 8'h34, hi: 8'h12, d: 32'h00000000, ok: 1'b1};
    vecs[2] = '{lo: 8'h35, hi: 8'h12, d: 32'h11111111, ok: 1'b0};
    vecs[3] = '{lo: 8'h34, hi: 8'h12, d: 32'hffffffff, ok: 1'b1};
    vecs[4] = '{lo: 8'h34, hi: 8'h13, d: 32'h22222222, ok: 1'b0};
    vecs[5] = '{lo: 8'h34, hi: 8'h12, d: 32'ha5a55a5a, ok: 1'b1};

    rst = 1'b1; ad = 8'h00; stb = 1'b0; ready = 1'b1; ovf_clr = 1'b0;
    #12;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_fill", 32'(fill), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_abort", 32'(abort), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_data", data, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single command, one-cycle latency, one-cycle valid with ready high.
    exp_q.push_back({16'h1234, 32'h12345678});
    send_cmd(8'h34, 8'h12, 32'h12345678, 1'b0, 1'b0);
    check("first_valid", 32'(valid), 32'd1);
    check("first_addr", 32'(addr), 32'h1234);
    check("first_data", data, 32'h12345678);
    @(posedge clk);
    #1;
    check("valid_one_cycle", 32'(valid), 32'd0);

    // Table of back-to-back commands, including both address mismatch bytes.
    abort_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].ok) exp_q.push_back({8'h12, vecs[i].lo, vecs[i].d});
      send_cmd(vecs[i].lo, vecs[i].hi, vecs[i].d, 1'b0, 1'b0);
    end
    repeat (3) @(posedge clk);
    #1;
    check("table_drain", 32'(exp_q.size()), 32'd0);
    check("table_no_abort", 32'(abort_cnt), 32'd0);

    // Restart in DATA (third byte) and in AHI.
    abort_cnt = 0;
    exp_q.push_back({16'h1234, 32'hcafef00d});
    drive_byte(8'h34, 1'b1); drive_byte(8'h12, 1'b0);
    drive_byte(8'h34, 1'b1); drive_byte(8'h12, 1'b0);
    drive_byte(8'h0d, 1'b0); drive_byte(8'hf0, 1'b0);
    drive_byte(8'hfe, 1'b0); drive_byte(8'hca, 1'b0);
    exp_q.push_back({16'h1234, 32'h11223344});
    drive_byte(8'h34, 1'b1); drive_byte(8'h34, 1'b1); drive_byte(8'h12, 1'b0);
    drive_byte(8'h44, 1'b0); drive_byte(8'h33, 1'b0);
    drive_byte(8'h22, 1'b0); drive_byte(8'h11, 1'b0);
    stb = 1'b0; ad = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("abort_drain", 32'(exp_q.size()), 32'd0);
    check("abort_pulses", 32'(abort_cnt), 32'd2);

    // Overflow: five commands into a depth-4 FIFO with no consumer.
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) exp_q.push_back({16'h1234, 32'h10000000 + 32'(i)});
      send_cmd(8'h34, 8'h12, 32'h10000000 + 32'(i), 1'b0, 1'b0);
    end
    check("ovf_fill", 32'(fill), 32'd4);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_head_data", data, 32'h10000000);
    send_cmd(8'h34, 8'h12, 32'h1000000f, 1'b0, 1'b1);
    check("ovf_drop_priority", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    ready   = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    check("ovf_drain", 32'(exp_q.size()), 32'd0);
    check("ovf_empty_fill", 32'(fill), 32'd0);

    // Completion while full with a same-cycle pop.
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back({16'h1234, 32'h20000000 + 32'(i)});
      send_cmd(8'h34, 8'h12, 32'h20000000 + 32'(i), (i == 4), 1'b0);
    end
    check("full_pp_fill", 32'(fill), 32'd4);
    check("full_pp_no_ovf", 32'(overflow), 32'd0);
    ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("full_pp_drain", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset between bytes 3 and 4, with an entry already queued.
    ready = 1'b0;
    send_cmd(8'h34, 8'h12, 32'h33333333, 1'b0, 1'b0);
    check("pre_rst_fill", 32'(fill), 32'd1);
    drive_byte(8'h34, 1'b1); drive_byte(8'h12, 1'b0); drive_byte(8'h78, 1'b0);
    rst = 1'b1;
    stb = 1'b0;
    ad  = 8'h00;
    #1;
    check("async_rst_valid", 32'(valid), 32'd0);
    check("async_rst_fill", 32'(fill), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst   = 1'b0;
    ready = 1'b1;
    exp_q.push_back({16'h1234, 32'h0badcafe});
    send_cmd(8'h34, 8'h12, 32'h0badcafe, 1'b0, 1'b0);
    check("post_rst_valid", 32'(valid), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_drain", 32'(exp_q.size()), 32'd0);

    // Masked address compare on the second instance.
    do_reset();
    m_abort_cnt = 0;
    send_cmd(8'h55, 8'h12, 32'hdeadbeef, 1'b0, 1'b0);
    check("mask_valid", 32'(m_valid), 32'd1);
    check("mask_addr", 32'(m_addr), 32'h1255);
    check("mask_data", m_data, 32'hdeadbeef);
    check("nomask_reject", 32'(valid), 32'd0);
    @(posedge clk);
    #1;
    send_cmd(8'h55, 8'h13, 32'h44444444, 1'b0, 1'b0);
    check("mask_hi_reject", 32'(m_valid), 32'd0);
    check("mask_hi_fill", 32'(m_fill), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("mask_no_abort", 32'(m_abort_cnt), 32'd0);
    check("mask_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
